sd_block_loader: RTL and testbench
==================================

Name: sd_block_loader

Overview:
Parametrised successor to the SD-to-RAM boot copier. Requests SD sectors from the SD reader, collects each sector's byte stream into one of two ping-pong sector buffers, and drains the other buffer to RAM as DATA_W-bit little-endian words through a valid/ack write port. Sector fetch therefore overlaps with the RAM drain. Adds configurable start sector, image size, RAM base address, word width, and bounded retry on SD read errors.

Parameters:
DATA_W, 32, RAM write word width; 32 or 64.
SECTOR_BYTES, 512, bytes per SD sector; power of 2.
BIN_SIZE, 32'h0080_0000, image bytes to copy; must be greater than 0.
START_SECTOR, 0, first SD sector of the image.
BASE_ADDR, 32'h8000_0000, RAM byte address of image byte 0.
ADDR_W, 32, RAM address width.
MAX_RETRY, 2, retries per sector after the first failed attempt.

Ports:
clk27mhz  in  1  system clock; all logic on the rising edge.
resetn  in  1  asynchronous, active-low reset.
start  in  1  pulse; begins a copy when idle.
rd_start  out  1  sector read request (level).
rd_sector  out  32  sector number; stable while rd_start=1.
in_en  in  1  in_byte valid this cycle.
in_byte  in  8  sector data byte, in order.
rd_done  in  1  pulse; SD reader finished the sector.
rd_err  in  1  pulse; SD reader failed the sector.
mem_we  out  1  write valid.
mem_addr  out  ADDR_W  byte address, DATA_W/8-aligned.
mem_wdata  out  DATA_W  write data; byte k of the word in bits [8k+7:8k].
mem_ack  in  1  write accepted this cycle.
busy  out  1  copy in progress.
done  out  1  sticky; whole image written.
error  out  1  sticky; retries exhausted.

Behaviour:
- Reset (async assert, sync release): all outputs 0; both buffers empty; FSMs idle.
- start with busy=0: clear done and error, set busy the next cycle, sector index = 0. start with busy=1 is ignored.
- Derived constants: NSEC = ceil(BIN_SIZE/SECTOR_BYTES); BPW = DATA_W/8.
- Fill FSM states: F_IDLE, F_REQ, F_WAIT, F_CHECK.
  - F_REQ: entered when a buffer is free and sectors remain. Sets rd_start=1 and rd_sector=START_SECTOR+index.
  - F_WAIT: rd_start is held; in_en bytes are written to the fill buffer at the byte counter. Bytes past SECTOR_BYTES are dropped.
  - On rd_done or rd_err: rd_start=0 the next cycle, then F_CHECK. rd_start stays low for at least 1 cycle between requests.
  - F_CHECK, success (rd_done with exactly SECTOR_BYTES bytes): mark buffer full, clear retry count, advance index.
  - F_CHECK, failure (rd_err, or a short sector): if retry count < MAX_RETRY, increment it and re-request the same sector; otherwise set error=1, busy=0, stop both FSMs. No further writes.
  - in_en outside F_WAIT is ignored.
- Drain FSM states: D_IDLE, D_WRITE.
  - Selects the oldest full buffer. Words per sector = SECTOR_BYTES/BPW, except the final sector: ceil(remaining bytes / BPW).
  - Image bytes beyond BIN_SIZE are never written. Unused high lanes of the final partial word are 0.
  - mem_addr = BASE_ADDR + image byte offset of the word.
  - mem_we, mem_addr and mem_wdata stay stable until the cycle mem_ack=1. The next word may be presented on the following cycle: 1 word/cycle when mem_ack is tied high.
  - After the buffer's last word is acked, the buffer becomes free.
- Overlap: the fill of sector n+1 may run while sector n drains. The fill FSM stalls in F_IDLE while both buffers are full.
- Completion: on the ack of the last image word, done=1 and busy=0 on the next cycle.
- Simultaneous rd_done and rd_err: treated as failure.
- Simultaneous free of a buffer by the drain and request by the fill in the same cycle: the fill may use that buffer on the next cycle.

Test Plan:
1. Basic copy. DATA_W=32, BIN_SIZE=1000, START_SECTOR=8, mem_ack=1, byte j of each sector = j&0xFF -> rd_sector=8 then 9; 250 writes, addr 0x8000_0000..0x8000_03E4; first wdata 0x03020100; done=1; bytes 488..511 of sector 9 are not written.
2. Partial final word. BIN_SIZE=1002 -> 251 writes; last is addr 0x8000_03E8, wdata 0x0000_E9E8. DATA_W=64 with BIN_SIZE=1000 -> 125 writes, first wdata 0x0706050403020100.
3. Backpressure and overlap. mem_ack asserted every 6th cycle -> rd_start for sector 9 asserts while sector 8 is draining; sector-10 request is withheld until a buffer frees; all words exact and in order.
4. Retry. rd_err on sector 9, first try -> re-request of 9 and success. Three rd_err on 9 with MAX_RETRY=2 -> error=1, busy=0, done=0, no writes after sector 8.
5. Short sector. rd_done after 500 bytes -> counted as a failure; sector re-requested.
6. Reset mid-drain. resetn low while mem_we=1 -> all outputs 0 immediately. A new start copies again from 0x8000_0000 with rd_sector=8.

Source files
------------

// File: rtl/sd_block_loader.sv
// SD-to-RAM image loader: fetches SD sectors into two ping-pong buffers while the
// other buffer drains to RAM as little-endian DATA_W-bit words over a valid/ack port.
module sd_block_loader #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned BIN_SIZE     = 32'h0080_0000,
  parameter int unsigned START_SECTOR = 0,
  parameter int unsigned BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic              clk27mhz,
  input  logic              resetn,
  input  logic              start,
  output logic              rd_start,
  output logic [31:0]       rd_sector,
  input  logic              in_en,
  input  logic [7:0]        in_byte,
  input  logic              rd_done,
  input  logic              rd_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int unsigned BPW        = DATA_W / 8;
  localparam int unsigned WPS        = SECTOR_BYTES / BPW;
  // Written as (n-1)/d+1 so a BIN_SIZE near 2^32 cannot overflow the rounding add.
  localparam int unsigned NSEC       = (BIN_SIZE - 1) / SECTOR_BYTES + 1;
  localparam int unsigned LAST_BYTES = BIN_SIZE - (NSEC - 1) * SECTOR_BYTES;
  localparam int unsigned LAST_WORDS = (LAST_BYTES + BPW - 1) / BPW;
  localparam int unsigned LAST_REM   = LAST_BYTES % BPW;
  localparam int unsigned LANE_W     = $clog2(BPW);
  localparam int unsigned SEC_SH     = $clog2(SECTOR_BYTES);
  localparam int unsigned BC_W       = SEC_SH + 1;
  localparam int unsigned WI_W       = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int unsigned RT_W       = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [BC_W-1:0] SB_CNT   = BC_W'(SECTOR_BYTES);
  localparam logic [RT_W-1:0] RT_MAX   = RT_W'(MAX_RETRY);
  localparam logic [WI_W-1:0] WI_FULL  = WI_W'(WPS - 1);
  localparam logic [WI_W-1:0] WI_LAST  = WI_W'(LAST_WORDS - 1);

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_REQ   = 2'd1;
  localparam logic [1:0] F_WAIT  = 2'd2;
  localparam logic [1:0] F_CHECK = 2'd3;
  localparam logic       D_IDLE  = 1'b0;
  localparam logic       D_WRITE = 1'b1;

  logic [1:0]        fstate_q, fstate_d;
  logic              dstate_q, dstate_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              rd_start_q, rd_start_d;
  logic [31:0]       sec_idx_q, sec_idx_d, drain_sec_q, drain_sec_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WI_W-1:0]   word_idx_q, word_idx_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic              fail_q, fail_d;
  logic              fill_sel_q, fill_sel_d, drain_sel_q, drain_sel_d;
  logic [1:0]        full_q, full_d;

  logic [DATA_W-1:0] buf_mem [2][WPS];
  logic              wr_en;
  logic [WI_W-1:0]   last_word;
  logic [DATA_W-1:0] lane_mask;
  logic [31:0]       offset;

  assign wr_en     = (fstate_q == F_WAIT) && in_en && !byte_cnt_q[BC_W-1];
  assign last_word = (drain_sec_q == NSEC - 1) ? WI_LAST : WI_FULL;

  // NOTE: sector buffers carry no reset; the full flags alone say which contents are valid.
  always_ff @(posedge clk27mhz) begin
    if (wr_en)
      buf_mem[fill_sel_q][byte_cnt_q[BC_W-2:LANE_W]][{byte_cnt_q[LANE_W-1:0], 3'b000} +: 8] <= in_byte;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    fstate_d = fstate_q;     dstate_d    = dstate_q;
    busy_d   = busy_q;       done_d      = done_q;      error_d     = error_q;
    rd_start_d = rd_start_q; sec_idx_d   = sec_idx_q;   drain_sec_d = drain_sec_q;
    byte_cnt_d = byte_cnt_q; word_idx_d  = word_idx_q;  retry_d     = retry_q;
    fail_d   = fail_q;       fill_sel_d  = fill_sel_q;  drain_sel_d = drain_sel_q;
    full_d   = full_q;

    if (wr_en) byte_cnt_d = byte_cnt_q + BC_W'(1);
    case (fstate_q)
      F_IDLE: if (busy_q && (sec_idx_q < NSEC) && !full_q[fill_sel_q]) begin
        fstate_d   = F_REQ;
        rd_start_d = 1'b1;
        byte_cnt_d = '0;
      end
      F_REQ: fstate_d = F_WAIT;
      F_WAIT: if (rd_done || rd_err) begin
        rd_start_d = 1'b0;
        fstate_d   = F_CHECK;
        fail_d     = rd_err || (byte_cnt_d != SB_CNT);
      end
      default: begin
        if (!fail_q) begin
          full_d[fill_sel_q] = 1'b1;
          fill_sel_d = ~fill_sel_q;
          retry_d    = '0;
          sec_idx_d  = sec_idx_q + 32'd1;
          fstate_d   = F_IDLE;
        end else if (retry_q < RT_MAX) begin
          retry_d    = retry_q + RT_W'(1);
          rd_start_d = 1'b1;
          byte_cnt_d = '0;
          fstate_d   = F_REQ;
        end else begin
          error_d  = 1'b1;
          busy_d   = 1'b0;
          fstate_d = F_IDLE;
        end
      end
    endcase

    // Buffers are filled and drained in strict alternation, so drain_sel is always the oldest.
    case (dstate_q)
      D_IDLE: if (busy_q && full_q[drain_sel_q]) begin
        dstate_d   = D_WRITE;
        word_idx_d = '0;
      end
      default: if (mem_ack) begin
        if (word_idx_q == last_word) begin
          full_d[drain_sel_q] = 1'b0;
          drain_sel_d = ~drain_sel_q;
          drain_sec_d = drain_sec_q + 32'd1;
          dstate_d    = D_IDLE;
          if (drain_sec_q == NSEC - 1) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end else begin
          word_idx_d = word_idx_q + WI_W'(1);
        end
      end
    endcase

    if (error_d) dstate_d = D_IDLE;

    if (start && !busy_q) begin
      done_d = 1'b0;  error_d = 1'b0;  busy_d = 1'b1;
      sec_idx_d = '0; drain_sec_d = '0; retry_d = '0;
      fill_sel_d = 1'b0; drain_sel_d = 1'b0; full_d = '0;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk27mhz or negedge resetn) begin
    if (!resetn) begin
      fstate_q <= F_IDLE;  dstate_q <= D_IDLE;
      busy_q <= 1'b0;      done_q <= 1'b0;      error_q <= 1'b0;
      rd_start_q <= 1'b0;  sec_idx_q <= '0;     drain_sec_q <= '0;
      byte_cnt_q <= '0;    word_idx_q <= '0;    retry_q <= '0;
      fail_q <= 1'b0;      fill_sel_q <= 1'b0;  drain_sel_q <= 1'b0;
      full_q <= '0;
    end else begin
      fstate_q <= fstate_d;    dstate_q <= dstate_d;
      busy_q <= busy_d;        done_q <= done_d;        error_q <= error_d;
      rd_start_q <= rd_start_d; sec_idx_q <= sec_idx_d; drain_sec_q <= drain_sec_d;
      byte_cnt_q <= byte_cnt_d; word_idx_q <= word_idx_d; retry_q <= retry_d;
      fail_q <= fail_d;        fill_sel_q <= fill_sel_d; drain_sel_q <= drain_sel_d;
      full_q <= full_d;
    end
  end

  // Zero the lanes of the final partial word that lie beyond the image end.
  always_comb begin
    lane_mask = '1;
    if ((LAST_REM != 0) && (drain_sec_q == NSEC - 1) && (word_idx_q == WI_LAST)) begin
      for (int k = 0; k < BPW; k++)
        lane_mask[8*k +: 8] = (k < LAST_REM) ? 8'hFF : 8'h00;
    end
  end

  assign offset    = (drain_sec_q << SEC_SH) + (32'(word_idx_q) << LANE_W);
  assign rd_start  = rd_start_q;
  assign rd_sector = rd_start_q ? (START_SECTOR + sec_idx_q) : '0;
  assign mem_we    = (dstate_q == D_WRITE);
  assign mem_addr  = mem_we ? (ADDR_W'(BASE_ADDR) + ADDR_W'(offset)) : '0;
  assign mem_wdata = mem_we ? (buf_mem[drain_sel_q][word_idx_q] & lane_mask) : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
endmodule

// File: tb/tb_sd_block_loader.sv
// Bench for sd_block_loader: an SD reader model feeds three configurations on a shared
// bus; expected RAM writes are queued per sector and compared as the DUT writes them.
module tb_sd_block_loader;
  logic        clk27mhz = 1'b0;
  logic        resetn;
  logic        start_a, start_b, start_c;
  logic        in_en, rd_done, rd_err, mem_ack;
  logic [7:0]  in_byte;

  logic        rd_start_a, rd_start_b, rd_start_c;
  logic [31:0] rd_sector_a, rd_sector_b, rd_sector_c;
  logic        mem_we_a, mem_we_b, mem_we_c;
  logic [31:0] mem_addr_a, mem_addr_b, mem_addr_c;
  logic [31:0] mem_wdata_a, mem_wdata_c;
  logic [63:0] mem_wdata_b;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, error_a, error_b, error_c;

  always #5 clk27mhz = ~clk27mhz;

  sd_block_loader #(.DATA_W(32), .BIN_SIZE(1000), .START_SECTOR(8)) u_dut_a (
    .clk27mhz(clk27mhz), .resetn(resetn), .start(start_a), .rd_start(rd_start_a),
    .rd_sector(rd_sector_a), .in_en(in_en), .in_byte(in_byte), .rd_done(rd_done),
    .rd_err(rd_err), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_ack(mem_ack), .busy(busy_a), .done(done_a), .error(error_a));

  sd_block_loader #(.DATA_W(64), .BIN_SIZE(1002), .START_SECTOR(8)) u_dut_b (
    .clk27mhz(clk27mhz), .resetn(resetn), .start(start_b), .rd_start(rd_start_b),
    .rd_sector(rd_sector_b), .in_en(in_en), .in_byte(in_byte), .rd_done(rd_done),
    .rd_err(rd_err), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_ack(mem_ack), .busy(busy_b), .done(done_b), .error(error_b));

  sd_block_loader #(.DATA_W(32), .BIN_SIZE(2000), .START_SECTOR(8)) u_dut_c (
    .clk27mhz(clk27mhz), .resetn(resetn), .start(start_c), .rd_start(rd_start_c),
    .rd_sector(rd_sector_c), .in_en(in_en), .in_byte(in_byte), .rd_done(rd_done),
    .rd_err(rd_err), .mem_we(mem_we_c), .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c),
    .mem_ack(mem_ack), .busy(busy_c), .done(done_c), .error(error_c));

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          cur_bin = 1000;
  int          cur_bpw = 4;
  int          ack_mode = 0;
  int          cyc = 0;
  logic [1:0]  sel = 2'd0;
  logic [31:0] first_addr, last_addr;
  logic [63:0] first_wdata, last_wdata;

  logic        m_we, m_rd_start, m_busy, m_done, m_error;
  logic [31:0] m_addr, m_rd_sector;
  logic [63:0] m_wdata;

  always_comb begin
    case (sel)
      2'd1: begin
        m_we = mem_we_b; m_addr = mem_addr_b; m_wdata = mem_wdata_b;
        m_rd_start = rd_start_b; m_rd_sector = rd_sector_b;
        m_busy = busy_b; m_done = done_b; m_error = error_b;
      end
      2'd2: begin
        m_we = mem_we_c; m_addr = mem_addr_c; m_wdata = {32'h0, mem_wdata_c};
        m_rd_start = rd_start_c; m_rd_sector = rd_sector_c;
        m_busy = busy_c; m_done = done_c; m_error = error_c;
      end
      default: begin
        m_we = mem_we_a; m_addr = mem_addr_a; m_wdata = {32'h0, mem_wdata_a};
        m_rd_start = rd_start_a; m_rd_sector = rd_sector_a;
        m_busy = busy_a; m_done = done_a; m_error = error_a;
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Image byte at sector offset j is j & 0xFF, matching the reader model below.
  task automatic push_sector(input int s);
    int nb, nw;
    wr_t e;
    nb = cur_bin - s * 512;
    if (nb > 512) nb = 512;
    nw = (nb + cur_bpw - 1) / cur_bpw;
    for (int w = 0; w < nw; w++) begin
      e.addr = 32'h8000_0000 + 32'(s * 512 + w * cur_bpw);
      e.data = '0;
      for (int k = 0; k < cur_bpw; k++) begin
        int o;
        o = w * cur_bpw + k;
        if (o < nb) e.data[8*k +: 8] = 8'(o);
      end
      exp_q.push_back(e);
    end
  endtask

  initial begin
    mem_ack = 1'b1;
    forever begin
      @(posedge clk27mhz); #1;
      cyc++;
      mem_ack = (ack_mode == 0) || (cyc % 6 == 0);
    end
  end

  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr;
  logic [63:0] hold_data;

  always @(negedge clk27mhz) begin
    if (hold_pend && m_we) begin
      check("hold_addr", m_addr, hold_addr);
      check("hold_data", m_wdata, hold_data);
    end
    if (m_we && mem_ack) begin
      check("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", m_addr, e.addr);
        check("wr_data", m_wdata, e.data);
      end
      if (wr_cnt == 0) begin
        first_addr  = m_addr;
        first_wdata = m_wdata;
      end
      last_addr  = m_addr;
      last_wdata = m_wdata;
      wr_cnt++;
    end
    hold_pend = m_we && !mem_ack;
    hold_addr = m_addr;
    hold_data = m_wdata;
  end

  // One sector transaction as the SD reader would perform it.
  task automatic serve(input int sec, input int nbytes, input bit err,
                       input bit chk_ovl, input int min_wr);
    int n;
    n = 0;
    while (!m_rd_start && n < 4000) begin
      @(posedge clk27mhz); #1;
      n++;
    end
    check("req_seen", m_rd_start, 1);
    check("rd_sector", m_rd_sector, sec);
    if (chk_ovl) check("overlap_we", m_we, 1);
    if (min_wr >= 0) check("req_after_free", wr_cnt >= min_wr, 1);
    repeat (2) begin @(posedge clk27mhz); #1; end
    for (int j = 0; j < nbytes; j++) begin
      in_en = 1'b1;
      in_byte = 8'(j);
      @(posedge clk27mhz); #1;
    end
    in_en = 1'b0;
    if (err) rd_err = 1'b1;
    else     rd_done = 1'b1;
    if (!err && nbytes == 512) push_sector(sec - 8);
    @(posedge clk27mhz); #1;
    rd_done = 1'b0;
    rd_err = 1'b0;
    check("req_drop", m_rd_start, 0);
  endtask

  task automatic begin_run(input logic [1:0] s, input int bin, input int bpw);
    sel = s;
    cur_bin = bin;
    cur_bpw = bpw;
    wr_cnt = 0;
    exp_q.delete();
    case (s)
      2'd1:    start_b = 1'b1;
      2'd2:    start_c = 1'b1;
      default: start_a = 1'b1;
    endcase
    @(posedge clk27mhz); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    check("start_busy", m_busy, 1);
    check("start_clr", {m_done, m_error}, 0);
  endtask

  task automatic finish_run(input int exp_writes);
    int n;
    n = 0;
    while (!m_done && !m_error && n < 20000) begin
      @(posedge clk27mhz); #1;
      n++;
    end
    check("done", m_done, 1);
    check("end_busy", {m_busy, m_error}, 0);
    repeat (4) begin @(posedge clk27mhz); #1; end
    check("wr_count", wr_cnt, exp_writes);
    check("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    resetn = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    in_en = 1'b0; in_byte = 8'h00; rd_done = 1'b0; rd_err = 1'b0;
    repeat (3) begin @(posedge clk27mhz); #1; end
    check("rst_ctrl", {rd_start_a, mem_we_a, busy_a, done_a, error_a}, 0);
    check("rst_addr", mem_addr_a, 0);
    check("rst_sector", rd_sector_a, 0);
    check("rst_wdata", mem_wdata_a, 0);
    resetn = 1'b1;
    @(posedge clk27mhz); #1;

    // Basic 32-bit copy of 1000 bytes from sectors 8 and 9.
    begin_run(2'd0, 1000, 4);
    serve(8, 512, 0, 0, -1);
    serve(9, 512, 0, 0, -1);
    finish_run(250);
    check("first_addr", first_addr, 32'h8000_0000);
    check("first_wdata", first_wdata, 64'h0302_0100);
    check("last_addr", last_addr, 32'h8000_03E4);

    // Short sector is a failure and is re-requested.
    begin_run(2'd0, 1000, 4);
    serve(8, 500, 0, 0, -1);
    serve(8, 512, 0, 0, -1);
    serve(9, 512, 0, 0, -1);
    finish_run(250);

    // Single read error then success.
    begin_run(2'd0, 1000, 4);
    serve(8, 512, 0, 0, -1);
    serve(9, 300, 1, 0, -1);
    serve(9, 512, 0, 0, -1);
    finish_run(250);

    // Retries exhausted on sector 9.
    begin_run(2'd0, 1000, 4);
    serve(8, 512, 0, 0, -1);
    serve(9, 100, 1, 0, -1);
    serve(9, 100, 1, 0, -1);
    serve(9, 100, 1, 0, -1);
    repeat (300) begin @(posedge clk27mhz); #1; end
    check("err_flag", m_error, 1);
    check("err_busy_done", {m_busy, m_done}, 0);
    check("err_req", m_rd_start, 0);
    check("err_wr_count", wr_cnt, 128);
    check("err_q_empty", exp_q.size(), 0);

    // Reset in the middle of a drain, then a clean restart.
    begin_run(2'd0, 1000, 4);
    serve(8, 512, 0, 0, -1);
    begin
      int n;
      n = 0;
      while (!m_we && n < 100) begin @(posedge clk27mhz); #1; n++; end
    end
    repeat (10) begin @(posedge clk27mhz); #1; end
    check("pre_rst_we", m_we, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_ctrl", {m_rd_start, m_we, m_busy, m_done, m_error}, 0);
    check("mid_rst_bus", {m_addr, m_wdata[31:0]}, 0);
    exp_q.delete();
    repeat (2) begin @(posedge clk27mhz); #1; end
    resetn = 1'b1;
    @(posedge clk27mhz); #1;
    begin_run(2'd0, 1000, 4);
    serve(8, 512, 0, 0, -1);
    serve(9, 512, 0, 0, -1);
    finish_run(250);
    check("restart_addr", first_addr, 32'h8000_0000);

    // 64-bit words with a partial final word.
    begin_run(2'd1, 1002, 8);
    serve(8, 512, 0, 0, -1);
    serve(9, 512, 0, 0, -1);
    finish_run(126);
    check("w64_first", first_wdata, 64'h0706_0504_0302_0100);
    check("w64_last_addr", last_addr, 32'h8000_03E8);
    check("w64_last_data", last_wdata, 64'h0000_0000_0000_E9E8);

    // Backpressure: fetch overlaps the drain and stalls while both buffers are full.
    ack_mode = 1;
    begin_run(2'd2, 2000, 4);
    serve(8, 512, 0, 0, -1);
    serve(9, 512, 0, 1, -1);
    repeat (20) begin @(posedge clk27mhz); #1; end
    check("withhold_req", m_rd_start, 0);
    serve(10, 512, 0, 0, 128);
    serve(11, 512, 0, 0, 256);
    finish_run(500);
    check("bp_last_addr", last_addr, 32'h8000_07CC);
    ack_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
